vip_edge_bbox_locator: RTL and testbench
========================================

Name: vip_edge_bbox_locator

Overview:
- Sits directly downstream of the Sobel edge detector and consumes its binary edge stream (vsync/href/clken plus 1-bit edge flag).
- Tracks pixel coordinates and accumulates per-row edge statistics, rejecting noisy rows.
- At each frame boundary, publishes the bounding box of the object region for the sorting controller.
- Output is a registered result bus with a one-cycle valid pulse per completed frame.

Parameters:
- IMG_W, 640, active pixels per line; pixels at x >= IMG_W are ignored.
- IMG_H, 480, active lines per frame; lines at y >= IMG_H are ignored.
- CNT_W, 12, width of coordinate and count registers; must satisfy 2^CNT_W > max(IMG_W, IMG_H).
- MIN_ROW_PIX, 4, minimum number of edge pixels in a row for that row to qualify.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  reset, asynchronous, active-low.
- pre_frame_vsync  in  1  frame sync; a rising edge marks frame start.
- pre_frame_href  in  1  line valid.
- pre_frame_clken  in  1  pixel enable.
- pre_img_bit  in  1  edge flag from the Sobel stage.
- bbox_x_min  out  CNT_W  left edge of the box.
- bbox_x_max  out  CNT_W  right edge of the box.
- bbox_y_min  out  CNT_W  top edge of the box.
- bbox_y_max  out  CNT_W  bottom edge of the box.
- bbox_found  out  1  at least one qualifying row in the last frame.
- bbox_valid  out  1  one-cycle strobe; result registers updated.

Behaviour:
- Reset values: all outputs 0. Internal counters, accumulators, edge-detect registers and the prev_frame_seen flag also reset to 0.
- Edge detection:
  - vsync_d1 and href_d1 registered.
  - vs_rise = vsync & ~vsync_d1.
  - h_fall = href_d1 & ~href.
- Pixel qualification: a pixel is valid when href & clken.
- x counter:
  - Increments on each valid pixel.
  - Saturates at 2^CNT_W-1.
  - Clears on h_fall and on vs_rise.
- y counter:
  - Increments on h_fall.
  - Saturates.
  - Clears on vs_rise.
- Row accumulator: a pixel contributes when valid & bit & x < IMG_W & y < IMG_H.
  - Contributions increment row_cnt (saturating) and update row_xmin (init all-ones) and row_xmax (init 0).
  - All three reset on h_fall and on vs_rise.
- Row commit: on h_fall with row_cnt >= MIN_ROW_PIX:
  - frame xmin = min(frame xmin, row_xmin).
  - frame xmax = max(frame xmax, row_xmax).
  - If frame_any = 0: ymin = y and frame_any = 1.
  - ymax = y.
- Frame latch on vs_rise:
  - If prev_frame_seen = 1, the output registers take the frame accumulators on the next clock edge and bbox_valid is high for exactly that one cycle.
  - bbox_found = frame_any. If frame_any = 0, all four coordinates are driven to 0.
  - Accumulators clear and prev_frame_seen is set to 1.
  - The first vs_rise after reset produces no bbox_valid, because the preceding frame was partial.
- Latency: bbox_valid is asserted in the cycle after the first clock edge at which vsync is sampled high, i.e. 1 cycle after the edge-detect register captures the rise.
- Coincident h_fall and vs_rise: the row commit is merged into the latched result using next-state values, so no row is lost. Accumulators then clear.
- h_fall with href already low (no pixels in the row): row_cnt = 0, so the row does not qualify, but y still increments.
- Reset mid-frame: everything clears, and the next vs_rise produces no output.
- Output registers hold their value between strobes.
- No backpressure: the consumer must sample on bbox_valid.

Decomposition:
- Shared package vip_pkg: defaults for IMG_W, IMG_H and CNT_W, plus a bbox record typedef {x_min, x_max, y_min, y_max, found}.
- One sub-module, vip_row_stats: the per-row count/min/max accumulator with clear and pixel-enable inputs, outputting row_cnt, row_xmin and row_xmax.
- The top level keeps the coordinate counters, row commit, frame latch and the first-frame flag.

Test Plan (IMG_W=16, IMG_H=8, CNT_W=12, MIN_ROW_PIX=2):
- Reset, then two frames with all bits 0 -> no valid after the first vsync rise; at the second rise, bbox_valid pulses once with found=0 and all coordinates 0.
- Frame with edges at x=3..9 on rows 2..5 -> next vsync rise gives found=1, x_min=3, x_max=9, y_min=2, y_max=5, valid high for exactly 1 cycle.
- Single edge pixel on row 1 (below MIN_ROW_PIX) plus a qualifying row 6 at x=4..5 -> y_min=6, y_max=6, x_min=4, x_max=5.
- Line of 20 pixels with edges at x=17..19 only -> row ignored (x >= IMG_W); found=0.
- Last row's href falls in the same cycle vsync rises, last row qualifies at x=0..15 -> y_max=7, x_min=0, x_max=15.
- rst_n pulsed low mid-frame -> outputs 0 immediately; next vsync rise gives no valid; the following rise gives a correct box.

Source files
------------

// File: rtl/vip_pkg.sv
// Shared defaults and the published bounding-box record for the VIP edge pipeline.
package vip_pkg;

  localparam int unsigned DEF_IMG_W       = 640;
  localparam int unsigned DEF_IMG_H       = 480;
  localparam int unsigned DEF_CNT_W       = 12;
  localparam int unsigned DEF_MIN_ROW_PIX = 4;

  typedef struct packed {
    logic [DEF_CNT_W-1:0] x_min;
    logic [DEF_CNT_W-1:0] x_max;
    logic [DEF_CNT_W-1:0] y_min;
    logic [DEF_CNT_W-1:0] y_max;
    logic                 found;
  } bbox_t;

endpackage

// File: rtl/vip_row_stats.sv
// Per-row edge statistics: saturating hit count plus leftmost/rightmost hit column.
module vip_row_stats
  import vip_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             pix_en,
  input  logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] row_cnt,
  output logic [CNT_W-1:0] row_xmin,
  output logic [CNT_W-1:0] row_xmax
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] xmin_q, xmin_d;
  logic [CNT_W-1:0] xmax_q, xmax_d;

  always_comb begin
    cnt_d  = cnt_q;
    xmin_d = xmin_q;
    xmax_d = xmax_q;
    if (clr) begin
      cnt_d  = '0;
      xmin_d = '1;
      xmax_d = '0;
    end else if (pix_en) begin
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      if (pix_x < xmin_q) xmin_d = pix_x;
      if (pix_x > xmax_q) xmax_d = pix_x;
    end
  end

  // xmin comes out of reset at its "empty row" value so a row cut by reset cannot report column 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      xmin_q <= '1;
      xmax_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      xmin_q <= xmin_d;
      xmax_q <= xmax_d;
    end
  end

  assign row_cnt  = cnt_q;
  assign row_xmin = xmin_q;
  assign row_xmax = xmax_q;

endmodule

// File: rtl/vip_edge_bbox_locator.sv
// Bounding box of qualifying edge rows per frame, published with a one-cycle strobe at each vsync rise.
module vip_edge_bbox_locator
  import vip_pkg::*;
#(
  parameter int unsigned IMG_W       = DEF_IMG_W,
  parameter int unsigned IMG_H       = DEF_IMG_H,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned MIN_ROW_PIX = DEF_MIN_ROW_PIX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pre_frame_vsync,
  input  logic             pre_frame_href,
  input  logic             pre_frame_clken,
  input  logic             pre_img_bit,
  output logic [CNT_W-1:0] bbox_x_min,
  output logic [CNT_W-1:0] bbox_x_max,
  output logic [CNT_W-1:0] bbox_y_min,
  output logic [CNT_W-1:0] bbox_y_max,
  output logic             bbox_found,
  output logic             bbox_valid
);

  localparam logic [CNT_W-1:0] IMG_W_C = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0] IMG_H_C = CNT_W'(IMG_H);
  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_ROW_PIX);

  logic             vsync_d1_q, href_d1_q;
  logic             vs_rise, h_fall, pix_valid, pix_hit, row_ok;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0] row_cnt, row_xmin, row_xmax;
  logic [CNT_W-1:0] fxmin_q, fxmin_d, fxmin_n;
  logic [CNT_W-1:0] fxmax_q, fxmax_d, fxmax_n;
  logic [CNT_W-1:0] fymin_q, fymin_d, fymin_n;
  logic [CNT_W-1:0] fymax_q, fymax_d, fymax_n;
  logic             fany_q, fany_d, fany_n;
  logic             prev_seen_q, prev_seen_d;
  logic             valid_q, valid_d;
  bbox_t            bbox_q, bbox_d;

  vip_row_stats #(.CNT_W(CNT_W)) u_row_stats (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (vs_rise | h_fall),
    .pix_en   (pix_hit),
    .pix_x    (x_q),
    .row_cnt  (row_cnt),
    .row_xmin (row_xmin),
    .row_xmax (row_xmax)
  );

  always_comb begin
    vs_rise   = pre_frame_vsync & ~vsync_d1_q;
    h_fall    = href_d1_q & ~pre_frame_href;
    pix_valid = pre_frame_href & pre_frame_clken;
    pix_hit   = pix_valid & pre_img_bit & (x_q < IMG_W_C) & (y_q < IMG_H_C);

    x_d = x_q;
    if (vs_rise || h_fall)            x_d = '0;
    else if (pix_valid && x_q != '1)  x_d = x_q + 1'b1;

    y_d = y_q;
    if (vs_rise)                      y_d = '0;
    else if (h_fall && y_q != '1)     y_d = y_q + 1'b1;

    // Row commit is folded into *_n so a vsync rise on the same cycle still latches that row.
    row_ok  = h_fall && (row_cnt >= MIN_C);
    fxmin_n = fxmin_q;
    fxmax_n = fxmax_q;
    fymin_n = fymin_q;
    fymax_n = fymax_q;
    fany_n  = fany_q;
    if (row_ok) begin
      if (row_xmin < fxmin_q) fxmin_n = row_xmin;
      if (row_xmax > fxmax_q) fxmax_n = row_xmax;
      if (!fany_q)            fymin_n = y_q;
      fymax_n = y_q;
      fany_n  = 1'b1;
    end

    fxmin_d     = fxmin_n;
    fxmax_d     = fxmax_n;
    fymin_d     = fymin_n;
    fymax_d     = fymax_n;
    fany_d      = fany_n;
    prev_seen_d = prev_seen_q;
    bbox_d      = bbox_q;
    valid_d     = 1'b0;
    if (vs_rise) begin
      if (prev_seen_q) begin
        valid_d      = 1'b1;
        bbox_d.found = fany_n;
        bbox_d.x_min = fany_n ? fxmin_n : '0;
        bbox_d.x_max = fany_n ? fxmax_n : '0;
        bbox_d.y_min = fany_n ? fymin_n : '0;
        bbox_d.y_max = fany_n ? fymax_n : '0;
      end
      fxmin_d     = '1;
      fxmax_d     = '0;
      fymin_d     = '0;
      fymax_d     = '0;
      fany_d      = 1'b0;
      prev_seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d1_q  <= 1'b0;
      href_d1_q   <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      fxmin_q     <= '0;
      fxmax_q     <= '0;
      fymin_q     <= '0;
      fymax_q     <= '0;
      fany_q      <= 1'b0;
      prev_seen_q <= 1'b0;
      valid_q     <= 1'b0;
      bbox_q      <= '0;
    end else begin
      vsync_d1_q  <= pre_frame_vsync;
      href_d1_q   <= pre_frame_href;
      x_q         <= x_d;
      y_q         <= y_d;
      fxmin_q     <= fxmin_d;
      fxmax_q     <= fxmax_d;
      fymin_q     <= fymin_d;
      fymax_q     <= fymax_d;
      fany_q      <= fany_d;
      prev_seen_q <= prev_seen_d;
      valid_q     <= valid_d;
      bbox_q      <= bbox_d;
    end
  end

  assign bbox_x_min = bbox_q.x_min;
  assign bbox_x_max = bbox_q.x_max;
  assign bbox_y_min = bbox_q.y_min;
  assign bbox_y_max = bbox_q.y_max;
  assign bbox_found = bbox_q.found;
  assign bbox_valid = valid_q;

endmodule

// File: tb/tb_vip_edge_bbox_locator.sv
// Frame-level bench: table of hand-built frames, reset corner case, then random frames vs a row-rule model.
module tb_vip_edge_bbox_locator;

  localparam int IMG_W       = 16;
  localparam int IMG_H       = 8;
  localparam int CNT_W       = 12;
  localparam int MIN_ROW_PIX = 2;

  typedef struct packed {
    logic             found;
    logic [CNT_W-1:0] x_min;
    logic [CNT_W-1:0] x_max;
    logic [CNT_W-1:0] y_min;
    logic [CNT_W-1:0] y_max;
  } exp_t;

  typedef struct packed {
    logic [9:0][31:0] rows;
    int               len;
    int               nrows;
    bit               coinc;
    bit               gaps;
    exp_t             exp;
  } frame_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             vsync, href, clken, img_bit;
  logic [CNT_W-1:0] x_min, x_max, y_min, y_max;
  logic             found, valid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vip_edge_bbox_locator #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .CNT_W(CNT_W), .MIN_ROW_PIX(MIN_ROW_PIX)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pre_frame_vsync (vsync),
    .pre_frame_href  (href),
    .pre_frame_clken (clken),
    .pre_img_bit     (img_bit),
    .bbox_x_min      (x_min),
    .bbox_x_max      (x_max),
    .bbox_y_min      (y_min),
    .bbox_y_max      (y_max),
    .bbox_found      (found),
    .bbox_valid      (valid)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic frame_t mk(input int len, input int nrows, input bit coinc);
    frame_t f;
    f       = '0;
    f.len   = len;
    f.nrows = nrows;
    f.coinc = coinc;
    return f;
  endfunction

  function automatic exp_t mk_exp(input bit fnd, input int xa, input int xb, input int ya, input int yb);
    exp_t e;
    e.found = fnd;
    e.x_min = CNT_W'(xa);
    e.x_max = CNT_W'(xb);
    e.y_min = CNT_W'(ya);
    e.y_max = CNT_W'(yb);
    return e;
  endfunction

  // Reference: qualify each in-image row by its hit count, then take extremes over qualifying rows.
  function automatic exp_t model(input frame_t f);
    int xmn, xmx, ymn, ymx, cnt, rmn, rmx;
    xmn = 1 << 20; xmx = -1; ymn = -1; ymx = -1;
    for (int y = 0; y < f.nrows && y < IMG_H; y++) begin
      cnt = 0; rmn = 1 << 20; rmx = -1;
      for (int x = 0; x < f.len && x < IMG_W; x++) begin
        if (f.rows[y][x]) begin
          cnt++;
          if (x < rmn) rmn = x;
          if (x > rmx) rmx = x;
        end
      end
      if (cnt >= MIN_ROW_PIX) begin
        if (ymn < 0) ymn = y;
        ymx = y;
        if (rmn < xmn) xmn = rmn;
        if (rmx > xmx) xmx = rmx;
      end
    end
    if (ymn < 0) return mk_exp(1'b0, 0, 0, 0, 0);
    return mk_exp(1'b1, xmn, xmx, ymn, ymx);
  endfunction

  task automatic drive_rows(input frame_t f);
    for (int y = 0; y < f.nrows; y++) begin
      for (int x = 0; x < f.len; x++) begin
        if (f.gaps && $urandom_range(0, 3) == 0) begin
          step(); href = 1'b1; clken = 1'b0; img_bit = 1'($urandom);
        end
        step(); href = 1'b1; clken = 1'b1; img_bit = f.rows[y][x];
      end
      if (!(f.coinc && y == f.nrows - 1)) begin
        step(); href = 1'b0; clken = 1'b0; img_bit = 1'b0;
        repeat (2) step();
      end
    end
  endtask

  // Raises vsync (dropping href at the same time), then watches a 4-cycle window for the strobe.
  task automatic rise_check(input bit exp_valid, input exp_t e, input string tag);
    int pulses, first, c_found, c_xa, c_xb, c_ya, c_yb;
    pulses = 0; first = -1;
    c_found = 0; c_xa = 0; c_xb = 0; c_ya = 0; c_yb = 0;
    step(); vsync = 1'b1; href = 1'b0; clken = 1'b0; img_bit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (valid) begin
        pulses++;
        if (first < 0) first = i;
        c_found = int'(found);
        c_xa = int'(x_min); c_xb = int'(x_max);
        c_ya = int'(y_min); c_yb = int'(y_max);
      end
    end
    check({tag, "_pulses"}, pulses, exp_valid ? 1 : 0);
    if (exp_valid) begin
      check({tag, "_latency"}, first, 1);
      check({tag, "_found"}, c_found, int'(e.found));
      check({tag, "_x_min"}, c_xa, int'(e.x_min));
      check({tag, "_x_max"}, c_xb, int'(e.x_max));
      check({tag, "_y_min"}, c_ya, int'(e.y_min));
      check({tag, "_y_max"}, c_yb, int'(e.y_max));
    end
    step(); vsync = 1'b0;
    repeat (3) step();
    if (exp_valid) begin
      @(negedge clk);
      check({tag, "_hold"}, int'({found, x_min, x_max, y_min, y_max}), int'(e));
    end
  endtask

  frame_t tbl [5];
  frame_t f;
  logic [31:0] m;
  int lo, hi;

  initial begin
    rst_n = 1'b0; vsync = 1'b0; href = 1'b0; clken = 1'b0; img_bit = 1'b0;

    tbl[0] = mk(16, 8, 1'b0);
    tbl[0].exp = mk_exp(1'b0, 0, 0, 0, 0);
    tbl[1] = mk(16, 8, 1'b0);
    for (int y = 2; y <= 5; y++) tbl[1].rows[y] = 32'h0000_03F8;
    tbl[1].exp = mk_exp(1'b1, 3, 9, 2, 5);
    tbl[2] = mk(16, 8, 1'b0);
    tbl[2].rows[1] = 32'h0000_0080;
    tbl[2].rows[6] = 32'h0000_0030;
    tbl[2].exp = mk_exp(1'b1, 4, 5, 6, 6);
    tbl[3] = mk(20, 8, 1'b0);
    for (int y = 0; y < 8; y++) tbl[3].rows[y] = 32'h000E_0000;
    tbl[3].exp = mk_exp(1'b0, 0, 0, 0, 0);
    tbl[4] = mk(16, 8, 1'b1);
    tbl[4].rows[7] = 32'h0000_FFFF;
    tbl[4].exp = mk_exp(1'b1, 0, 15, 7, 7);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", int'(valid), 0);
    check("reset_found", int'(found), 0);
    check("reset_coords", int'({x_min, x_max, y_min, y_max}), 0);
    step(); rst_n = 1'b1;

    drive_rows(mk(16, 4, 1'b0));
    rise_check(1'b0, '0, "first_rise");

    for (int i = 0; i < 5; i++) begin
      drive_rows(tbl[i]);
      rise_check(1'b1, tbl[i].exp, $sformatf("tbl%0d", i));
    end

    // Reset in the middle of a row while the outputs hold a nonzero box.
    f = mk(16, 2, 1'b0);
    f.rows[1] = 32'h0000_0FF0;
    drive_rows(f);
    step(); href = 1'b1; clken = 1'b1; img_bit = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", int'(valid), 0);
    check("midrst_found", int'(found), 0);
    check("midrst_coords", int'({x_min, x_max, y_min, y_max}), 0);
    step(); href = 1'b0; clken = 1'b0; img_bit = 1'b0;
    step(); rst_n = 1'b1;
    f = mk(16, 5, 1'b0);
    f.rows[3] = 32'h0000_00FF;
    drive_rows(f);
    rise_check(1'b0, '0, "post_rst_rise");
    f = mk(16, 8, 1'b0);
    for (int y = 1; y <= 3; y++) f.rows[y] = 32'h0000_1FE0;
    drive_rows(f);
    rise_check(1'b1, mk_exp(1'b1, 5, 12, 1, 3), "post_rst_box");

    for (int k = 0; k < 12; k++) begin
      f = mk($urandom_range(16, 20), $urandom_range(6, 10), 1'($urandom_range(0, 1)));
      f.gaps = 1'b1;
      for (int y = 0; y < f.nrows; y++) begin
        m = '0;
        case ($urandom_range(0, 3))
          0: m = '0;
          1: m[$urandom_range(0, 19)] = 1'b1;
          2: m = $urandom;
          default: begin
            lo = $urandom_range(0, 19);
            hi = $urandom_range(lo, 19);
            for (int b = lo; b <= hi; b++) m[b] = 1'b1;
          end
        endcase
        f.rows[y] = m;
      end
      f.exp = model(f);
      drive_rows(f);
      rise_check(1'b1, f.exp, $sformatf("rand%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
